// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared 7-segment definitions for the display blocks.
//   Patterns are {a,b,c,d,e,f,g}, with bit 6 = segment a, and active-high
//   (1 = segment lit) before any pin-polarity inversion.
// Contents:
//   segPattern_t      7-bit segment pattern type
//   SEG_*             pattern constants (hex digits, P, dash, blank)
//   hexPattern()      nibble -> hex glyph helper
// ---------------------------------------------------------------------------
package seg_pkg;

  localparam int SEG_WIDTH = 7;

  typedef logic [SEG_WIDTH-1:0] segPattern_t;

  localparam segPattern_t SEG_BLANK = 7'b0000000;
  localparam segPattern_t SEG_0     = 7'b1111110;
  localparam segPattern_t SEG_1     = 7'b0110000;
  localparam segPattern_t SEG_2     = 7'b1101101;
  localparam segPattern_t SEG_3     = 7'b1111001;
  localparam segPattern_t SEG_4     = 7'b0110011;
  localparam segPattern_t SEG_5     = 7'b1011011;
  localparam segPattern_t SEG_6     = 7'b1011111;
  localparam segPattern_t SEG_7     = 7'b1110000;
  localparam segPattern_t SEG_8     = 7'b1111111;
  localparam segPattern_t SEG_9     = 7'b1111011;
  localparam segPattern_t SEG_A     = 7'b1110111;
  localparam segPattern_t SEG_B     = 7'b0011111;
  localparam segPattern_t SEG_C     = 7'b1001110;
  localparam segPattern_t SEG_D     = 7'b0111101;
  localparam segPattern_t SEG_E     = 7'b1001111;
  localparam segPattern_t SEG_F     = 7'b1000111;
  localparam segPattern_t SEG_P     = 7'b1100111;
  localparam segPattern_t SEG_DASH  = 7'b0000001;

  // Glyph for a hex nibble 0..F (b and d are the lowercase shapes so they
  // stay distinguishable from 8 and 0).
  function automatic segPattern_t hexPattern(input logic [3:0] nib);
    segPattern_t pat;
    case (nib)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = SEG_A;
      4'hB:    pat = SEG_B;
      4'hC:    pat = SEG_C;
      4'hD:    pat = SEG_D;
      4'hE:    pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_char_decode.sv
// ---------------------------------------------------------------------------
// seg_char_decode
// Combinational ASCII -> 7-segment character ROM.
//   Recognised: '0'-'9', 'A'-'F', 'P', '-'. Everything else (including
//   space and lowercase) decodes to blank.
// Ports:
//   charIn  [7:0]  ASCII code
//   segOut  [6:0]  active-high pattern {a,b,c,d,e,f,g}
// ---------------------------------------------------------------------------
import seg_pkg::*;

module seg_char_decode (
  input  logic [7:0]  charIn,
  output segPattern_t segOut
);

  always_comb begin
    segOut = SEG_BLANK;
    if (charIn >= 8'h30 && charIn <= 8'h39) begin
      segOut = hexPattern(charIn[3:0]);
    end else if (charIn >= 8'h41 && charIn <= 8'h46) begin
      // 'A' is 0x41, so low nibble + 9 gives the hex value 10..15
      segOut = hexPattern(charIn[3:0] + 4'd9);
    end else if (charIn == 8'h50) begin
      segOut = SEG_P;
    end else if (charIn == 8'h2D) begin
      segOut = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// ---------------------------------------------------------------------------
// seg_display_ctrl
// Multiplexed 7-segment display controller with a shift-in character buffer.
//   Each accepted ASCII byte is decoded and shifted into digit 0 (rightmost),
//   pushing older characters left. Digits are scanned one at a time for
//   SCAN_DIV cycles each; the first cycle of every slot shows blank to avoid
//   ghosting while the digit select changes.
// Optional feature macro: SEG_BLINK_EN -- adds a blink phase that blanks
//   digits selected by blink_mask during every other BLINK_DIV-cycle window.
// Parameters:
//   NUM_DIGITS     number of digits (1..8)
//   SCAN_DIV       cycles per digit slot (>=2)
//   SEG_ACTIVE_LOW 1 inverts both outputs at the pins
//   BLINK_DIV      cycles per blink half-period
// Ports:
//   clock              system clock, rising edge
//   reset              asynchronous active-high reset
//   data_in   [7:0]    ASCII character
//   data_valid         accept data_in this cycle
//   clear              blank the whole buffer (wins over data_valid)
//   blink_mask[N-1:0]  per-digit blink request
//   segments  [6:0]    registered {a..g}, bit 6 = a
//   digit_en  [N-1:0]  registered one-hot digit select, bit 0 = rightmost
// ---------------------------------------------------------------------------
import seg_pkg::*;

module seg_display_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int BLINK_DIV      = 25000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            data_in,
  input  logic                  data_valid,
  input  logic                  clear,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic [6:0]            segments,
  output logic [NUM_DIGITS-1:0] digit_en
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  // XOR masks applied as the very last step before the output registers
  localparam logic [6:0]            SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] EN_POL  = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  // -------------------------------------------------------------------------
  // Character decode and digit buffer
  // -------------------------------------------------------------------------
  segPattern_t decoded;

  seg_char_decode uDecode (
    .charIn (data_in),
    .segOut (decoded)
  );

  segPattern_t digitBuf_reg [NUM_DIGITS];
  segPattern_t shiftSrc     [NUM_DIGITS];

  // Each entry loads from its right-hand neighbour; digit 0 loads the new char.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : gShift
      if (gi == 0) begin : gHead
        assign shiftSrc[gi] = decoded;
      end else begin : gBody
        assign shiftSrc[gi] = digitBuf_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digitBuf_reg[i] <= SEG_BLANK;
    end else if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) digitBuf_reg[i] <= SEG_BLANK;
    end else if (data_valid) begin
      for (int i = 0; i < NUM_DIGITS; i++) digitBuf_reg[i] <= shiftSrc[i];
    end
  end

  // -------------------------------------------------------------------------
  // Scan counter and digit index
  // -------------------------------------------------------------------------
  logic [SCAN_W-1:0] scanCnt_reg, scanCnt_next;
  logic [IDX_W-1:0]  digitIdx_reg, digitIdx_next;

  always_comb begin
    scanCnt_next  = scanCnt_reg + 1'b1;
    digitIdx_next = digitIdx_reg;
    if (scanCnt_reg == SCAN_LAST) begin
      scanCnt_next  = '0;
      digitIdx_next = (digitIdx_reg == IDX_LAST) ? '0 : digitIdx_reg + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scanCnt_reg  <= '0;
      digitIdx_reg <= '0;
    end else begin
      scanCnt_reg  <= scanCnt_next;
      digitIdx_reg <= digitIdx_next;
    end
  end

  // -------------------------------------------------------------------------
  // Blink phase
  // -------------------------------------------------------------------------
  logic blinkHide;

`ifdef SEG_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blinkCnt_reg;
  logic               blinkPhase_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blinkCnt_reg   <= '0;
      blinkPhase_reg <= 1'b0;
    end else if (blinkCnt_reg == BLINK_LAST) begin
      blinkCnt_reg   <= '0;
      blinkPhase_reg <= ~blinkPhase_reg;
    end else begin
      blinkCnt_reg   <= blinkCnt_reg + 1'b1;
    end
  end

  assign blinkHide = blink_mask[digitIdx_reg] & blinkPhase_reg;
`else
  // Blink hardware is absent; the mask input and divider are don't-cares.
  localparam int unusedBlinkDiv = BLINK_DIV;
  logic unusedBlinkMask;
  assign unusedBlinkMask = ^blink_mask;
  assign blinkHide       = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
  segPattern_t           segPre;
  logic [NUM_DIGITS-1:0] enPre;

  always_comb begin
    enPre               = '0;
    enPre[digitIdx_reg] = 1'b1;
    // Slot's first cycle is blank while digit_en moves to the new digit.
    if (scanCnt_reg == '0 || blinkHide) begin
      segPre = SEG_BLANK;
    end else begin
      segPre = digitBuf_reg[digitIdx_reg];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      segments <= SEG_POL;
      digit_en <= EN_POL;
    end else begin
      segments <= segPre ^ SEG_POL;
      digit_en <= enPre ^ EN_POL;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_display_ctrl
// Two instances (active-high and active-low pins) share all stimulus. The
// reference model holds the display contents as an array of glyphs and
// predicts the pins from the time elapsed since reset.
// ---------------------------------------------------------------------------
module tb_seg_display_ctrl;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 16;
`ifdef SEG_BLINK_EN
  localparam bit BLINK_BUILT = 1'b1;
`else
  localparam bit BLINK_BUILT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    data_in = 8'h00;
  logic          data_valid = 1'b0;
  logic          clear = 1'b0;
  logic [ND-1:0] blink_mask = '0;
  logic [6:0]    segA, segB;
  logic [ND-1:0] enA, enB;

  seg_display_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(0), .BLINK_DIV(BD)) dutA (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .clear(clear), .blink_mask(blink_mask), .segments(segA), .digit_en(enA)
  );

  seg_display_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1), .BLINK_DIV(BD)) dutB (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .clear(clear), .blink_mask(blink_mask), .segments(segB), .digit_en(enB)
  );

  always #5 clock = ~clock;

  // Clock edges seen since reset was released.
  int edgeCount;
  always @(posedge clock or posedge reset) begin
    if (reset) edgeCount <= 0;
    else       edgeCount <= edgeCount + 1;
  end

  int checks = 0;
  int fails  = 0;
  logic [6:0] modelBuf [ND];

  function automatic logic [6:0] refDecode(input logic [7:0] c);
    case (c)
      "0": return 7'b1111110;  "1": return 7'b0110000;
      "2": return 7'b1101101;  "3": return 7'b1111001;
      "4": return 7'b0110011;  "5": return 7'b1011011;
      "6": return 7'b1011111;  "7": return 7'b1110000;
      "8": return 7'b1111111;  "9": return 7'b1111011;
      "A": return 7'b1110111;  "B": return 7'b0011111;
      "C": return 7'b1001110;  "D": return 7'b0111101;
      "E": return 7'b1001111;  "F": return 7'b1000111;
      "P": return 7'b1100111;  "-": return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic modelClear();
    for (int i = 0; i < ND; i++) modelBuf[i] = 7'b0;
  endtask

  // One input transaction: byte and/or clear presented for one cycle.
  task automatic drive(input logic v, input logic c, input logic [7:0] b);
    @(negedge clock);
    data_in = b; data_valid = v; clear = c;
    @(negedge clock);
    data_valid = 1'b0; clear = 1'b0;
    if (c) modelClear();
    else if (v) begin
      for (int i = ND-1; i > 0; i--) modelBuf[i] = modelBuf[i-1];
      modelBuf[0] = refDecode(b);
    end
    $display("txn valid=%0b clear=%0b data=0x%02h -> buf %b %b %b %b",
             v, c, b, modelBuf[3], modelBuf[2], modelBuf[1], modelBuf[0]);
  endtask

  // Check n consecutive cycles of both instances against the model.
  task automatic checkScan(input int n, input string tag);
    int k, idx;
    logic [6:0]    expSeg;
    logic [ND-1:0] expEn;
    repeat (n) begin
      @(negedge clock);
      k      = edgeCount - 1;
      idx    = (k / SD) % ND;
      expEn  = ND'(1) << idx;
      expSeg = (k % SD == 0) ? 7'b0 : modelBuf[idx];
      if (BLINK_BUILT && blink_mask[idx] && ((k / BD) % 2 == 1)) expSeg = 7'b0;
      checks += 4;
      if (segA !== expSeg) begin
        fails++; $display("FAIL %s segA k=%0d got %b want %b", tag, k, segA, expSeg);
      end
      if (enA !== expEn) begin
        fails++; $display("FAIL %s enA k=%0d got %b want %b", tag, k, enA, expEn);
      end
      if (segB !== ~expSeg) begin
        fails++; $display("FAIL %s segB k=%0d got %b want %b", tag, k, segB, ~expSeg);
      end
      if (enB !== ~expEn) begin
        fails++; $display("FAIL %s enB k=%0d got %b want %b", tag, k, enB, ~expEn);
      end
    end
  endtask

  task automatic checkInactive(input string tag);
    checks += 4;
    if (segA !== 7'h00) begin fails++; $display("FAIL %s segA got %b want 0000000", tag, segA); end
    if (enA !== 4'h0)   begin fails++; $display("FAIL %s enA got %b want 0000", tag, enA); end
    if (segB !== 7'h7F) begin fails++; $display("FAIL %s segB got %b want 1111111", tag, segB); end
    if (enB !== 4'hF)   begin fails++; $display("FAIL %s enB got %b want 1111", tag, enB); end
  endtask

  task automatic applyReset();
    @(negedge clock);
    reset = 1'b1;
    modelClear();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    modelClear();
    @(negedge clock);
    checkInactive("reset_hold");
    reset = 1'b0;
    checkScan(2 * ND * SD, "reset_scan");
  endtask

  task automatic test_basic();
    applyReset();
    drive(1, 0, 8'h31);
    drive(1, 0, 8'h50);
    checkScan(ND * SD + 4, "basic_1P");
  endtask

  task automatic test_clear_priority();
    drive(1, 0, "7");
    drive(1, 0, "8");
    drive(1, 1, 8'h35);
    checkScan(ND * SD, "clear_prio");
  endtask

  task automatic test_shift();
    drive(1, 0, 8'h7E);
    checkScan(ND * SD, "tilde_blank");
    drive(1, 0, "1"); drive(1, 0, "2"); drive(1, 0, "3");
    drive(1, 0, "4"); drive(1, 0, "5");
    checkScan(ND * SD, "shift_2345");
  endtask

  task automatic test_random();
    logic [7:0] pool [12] = '{"0", "9", "A", "C", "E", "F", "P", "-", " ", "b", "1", "Z"};
    logic [7:0] b;
    for (int g = 0; g < 6; g++) begin
      for (int t = 0; t < 6; t++) begin
        b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
        drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0), b);
      end
      checkScan(ND * SD, "random");
    end
  endtask

  task automatic test_reset_midop();
    drive(1, 0, "8"); drive(1, 0, "8");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    modelClear();
    #1;
    checkInactive("async_reset");
    @(negedge clock);
    checkInactive("reset_midop_hold");
    reset = 1'b0;
    checkScan(ND * SD, "after_midop");
  endtask

  task automatic test_blink();
    applyReset();
    blink_mask = 4'b0001;
    drive(1, 0, "8"); drive(1, 0, "8"); drive(1, 0, "8"); drive(1, 0, "8");
    checkScan(6 * BD, "blink");
    blink_mask = '0;
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 8; t++) drive(1, 0, 8'("0" + t));
    checkScan(ND * SD, "back_to_back");
  endtask

  initial begin
    modelClear();
    test_reset();
    test_basic();
    test_clear_priority();
    test_shift();
    test_random();
    test_reset_midop();
    test_blink();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
